// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame bit counts.
// The PARITY state and 11-bit frame exist only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } uart_state_e;

  localparam int DATA_BITS  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: power-of-two depth, registered occupancy count, full/empty flags.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push_ok, pop_ok;

  // A push against a full FIFO is dropped even if a pop happens the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// FIFO-buffered UART transmitter, 8N1; define UART_TX_PARITY_EN for 8E1 (even parity).
// Back-to-back frames leave STOP straight into START when bytes are queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       write_enable,
  output logic       tx,
  output logic       full,
  output logic       busy,
  output logic       overflow
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_e state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    fifo_rdata;
  logic          fifo_empty, fifo_pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par_bit;
`endif

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign fifo_pop = ~fifo_empty &
                    ((state == ST_IDLE) | ((state == ST_STOP) & bit_end));
  assign busy     = (state != ST_IDLE) | ~fifo_empty;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (write_enable),
    .pop   (fifo_pop),
    .wdata (data),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      if (write_enable && full) overflow <= 1'b1;
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (!fifo_empty) begin
            shreg <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par_bit <= ^fifo_rdata;
`endif
            state <= ST_START;
            tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            state    <= ST_DATA;
          end else baud_cnt <= baud_cnt + BAUD_ONE;
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx    <= par_bit;
              state <= ST_PARITY;
`else
              tx    <= 1'b1;
              state <= ST_STOP;
`endif
            end else begin
              // Shift register keeps the next bit at [1] so tx stays a plain flop.
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else baud_cnt <= baud_cnt + BAUD_ONE;
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= ST_STOP;
          end else baud_cnt <= baud_cnt + BAUD_ONE;
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (!fifo_empty) begin
              shreg <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
              par_bit <= ^fifo_rdata;
`endif
              tx    <= 1'b0;
              state <= ST_START;
            end else begin
              tx    <= 1'b1;
              state <= ST_IDLE;
            end
          end else baud_cnt <= baud_cnt + BAUD_ONE;
        end
        default: begin
          state    <= ST_IDLE;
          tx       <= 1'b1;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLK_HZ=16, BAUD=1: frame table, corner sequences, random traffic
// against a timeline model of scheduled frames.
module tb_uart_tx;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = CPB * NB;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       write_enable = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx, full, busy, overflow;

  always #5 clock = ~clock;

  uart_tx #(.CLK_HZ(16), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .data         (data),
    .write_enable (write_enable),
    .tx           (tx),
    .full         (full),
    .busy         (busy),
    .overflow     (overflow)
  );

  typedef struct {
    int         start;
    logic [7:0] d;
  } frame_t;

  typedef struct {
    logic [7:0]  d;
    logic [9:0]  f8n1;
    logic [10:0] fpar;
  } vec_t;

  frame_t frames[$];
  int     cyc = 0;
  int     stream_end = 0;
  bit     ovf_m = 1'b0;
  int     n_vec = 0;
  int     n_err = 0;

  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // One clock: advance the frame timeline with the inputs seen at this edge, then
  // compare every output against the timeline.
  task automatic tick();
    int occ, st, q;
    logic tx_e, busy_e;
    @(posedge clock);
    cyc++;
    if (!reset) begin
      frames.delete();
      stream_end = 0;
      ovf_m = 1'b0;
    end else if (write_enable) begin
      occ = 0;
      foreach (frames[i]) if (frames[i].start > cyc - 1) occ++;
      if (occ >= DEPTH) ovf_m = 1'b1;
      else begin
        st = (cyc + 1 > stream_end) ? cyc + 1 : stream_end;
        frames.push_back('{start: st, d: data});
        stream_end = st + F;
      end
    end
    #1;
    tx_e = 1'b1; busy_e = 1'b0; q = 0;
    foreach (frames[i]) begin
      if (cyc >= frames[i].start && cyc < frames[i].start + F)
        tx_e = frame_bit(frames[i].d, (cyc - frames[i].start) / CPB);
      if (frames[i].start + F > cyc) busy_e = 1'b1;
      if (frames[i].start > cyc) q++;
    end
    check("model_tx", tx, tx_e);
    check("model_busy", busy, busy_e);
    check("model_full", full, q == DEPTH);
    check("model_overflow", overflow, ovf_m);
    while (frames.size() > 0 && frames[0].start + F <= cyc) void'(frames.pop_front());
  endtask

  task automatic write_byte(input logic [7:0] b);
    write_enable = 1'b1;
    data = b;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle timeout cyc=%0d budget=%0d", cyc, budget);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  vec_t tbl[6];

  initial begin
    int w, s, lows;
    logic [10:0] fr;

    tbl[0] = '{8'h55, 10'b1_01010101_0, 11'b1_0_01010101_0};
    tbl[1] = '{8'h07, 10'b1_00000111_0, 11'b1_1_00000111_0};
    tbl[2] = '{8'h03, 10'b1_00000011_0, 11'b1_0_00000011_0};
    tbl[3] = '{8'hA5, 10'b1_10100101_0, 11'b1_0_10100101_0};
    tbl[4] = '{8'h00, 10'b1_00000000_0, 11'b1_0_00000000_0};
    tbl[5] = '{8'hFF, 10'b1_11111111_0, 11'b1_0_11111111_0};

    repeat (3) tick();
    check("reset_tx", tx, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_full", full, 1'b0);
    check("reset_overflow", overflow, 1'b0);
    reset = 1'b1;
    tick();

    // Single frames from idle: start bit one cycle after the write, each bit CPB cycles.
    for (int v = 0; v < 6; v++) begin
`ifdef UART_TX_PARITY_EN
      fr = tbl[v].fpar;
`else
      fr = {1'b0, tbl[v].f8n1};
`endif
      write_byte(tbl[v].d);
      check("tbl_idle_at_write", tx, 1'b1);
      tick();
      check("tbl_start_low", tx, 1'b0);
      for (int j = 0; j < NB; j++) begin
        check("tbl_bit_first", tx, fr[j]);
        repeat (CPB - 1) tick();
        check("tbl_bit_last", tx, fr[j]);
        tick();
      end
      check("tbl_busy_done", busy, 1'b0);
      repeat (3) tick();
    end

    // Three consecutive writes: gapless frames.
    w = cyc + 1;
    write_byte(8'h01);
    write_byte(8'h80);
    write_byte(8'hFF);
    wait_idle(4 * F);
    check_int("b2b_cycles", cyc - w, 3 * F + 1);

    // Six consecutive writes: fifth fills the FIFO, sixth is dropped.
    w = cyc + 1;
    for (int k = 0; k < 5; k++) write_byte(8'(8'h10 + k));
    check("burst_full_after_5", full, 1'b1);
    check("burst_no_ovf_yet", overflow, 1'b0);
    write_byte(8'h99);
    check("burst_overflow", overflow, 1'b1);
    wait_idle(6 * F);
    check_int("burst_cycles", cyc - w, 5 * F + 1);
    check("burst_ovf_sticky", overflow, 1'b1);
    pulse_reset();
    check("ovf_cleared", overflow, 1'b0);
    tick();

    // Reset during DATA bit 3 of 0xA5 with another byte queued.
    write_byte(8'hA5);
    s = cyc + 1;
    write_byte(8'h00);
    while (cyc < s + 4 * CPB + 6) tick();
    pulse_reset();
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_full", full, 1'b0);
    lows = 0;
    for (int k = 0; k < 2 * F; k++) begin
      tick();
      if (tx === 1'b0) lows++;
    end
    check_int("abort_no_resume", lows, 0);

    // Push on the STOP->START pop edge with one entry queued.
    w = cyc + 1;
    write_byte(8'h3C);
    write_byte(8'hC3);
    while (cyc < w + 1 + F - 1) tick();
    write_byte(8'h5A);
    check("popush_not_full", full, 1'b0);
    check("popush_start", tx, 1'b0);
    wait_idle(4 * F);
    check_int("popush_cycles", cyc - w, 3 * F + 1);

    // Random traffic with occasional bursts and resets.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 399) == 0) begin
        for (int b = 0; b < 6; b++) write_byte(8'($urandom));
      end else begin
        write_enable = ($urandom_range(0, 99) < 4);
        data = 8'($urandom);
        reset = ($urandom_range(0, 1499) != 0);
        tick();
        write_enable = 1'b0;
        reset = 1'b1;
      end
    end
    wait_idle(8 * F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
